// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types and helpers for the integer/float conversion path.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } fp_state_e;

    function automatic int fp_bias(input int exp_bit);
        return (1 << (exp_bit - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_norm_step.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_step
//  Description : One binary-search normalisation step: shift left by 2^k when
//                the top 2^k bits of the value are all zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_norm_step #(
    parameter int N_BIT   = 32,
    parameter int LOG_BIT = 5
) (
    input  logic [N_BIT-1:0]   value_i,
    input  logic [LOG_BIT-1:0] k_i,
    output logic [N_BIT-1:0]   shifted_o,
    output logic               taken_o
);

    logic [N_BIT-1:0] w_amt;
    logic [N_BIT-1:0] w_mask;
    logic             w_taken;

    always_comb begin
        w_amt   = {{(N_BIT-1){1'b0}}, 1'b1} << k_i;
        w_mask  = ~({N_BIT{1'b1}} >> w_amt);
        w_taken = ((value_i & w_mask) == '0);
    end

    assign taken_o   = w_taken;
    assign shifted_o = w_taken ? (value_i << w_amt) : value_i;

endmodule
`default_nettype wire

// File: rtl/fp_from_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp_from_int
//  Description : Multi-cycle signed/unsigned integer to float converter,
//                round-toward-zero, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_from_int
    import fp_pkg::*;
#(
    parameter int LOG_BIT = 5,
    parameter int EXP_BIT = 8,
    parameter int N_BIT   = 1 << LOG_BIT,
    parameter int MAN_BIT = N_BIT - EXP_BIT - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] in_int,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] out_fp
);

    localparam int c_BIAS = fp_bias(EXP_BIT);

    typedef struct packed {
        logic               sign;
        logic [EXP_BIT-1:0] exp;
        logic [MAN_BIT-1:0] man;
    } fp_word_t;

    fp_state_e          state_q,     state_d;
    logic               sign_q,      sign_d;
    logic [N_BIT-1:0]   mag_q,       mag_d;
    logic [LOG_BIT-1:0] step_q,      step_d;
    logic [LOG_BIT-1:0] lz_q,        lz_d;
    fp_word_t           out_fp_q,    out_fp_d;
    logic               out_valid_q, out_valid_d;

    logic [N_BIT-1:0]   w_shifted;
    logic               w_taken;
    logic [EXP_BIT-1:0] w_exp;

    fp_norm_step #(
        .N_BIT   (N_BIT),
        .LOG_BIT (LOG_BIT)
    ) u_norm_step (
        .value_i   (mag_q),
        .k_i       (step_q),
        .shifted_o (w_shifted),
        .taken_o   (w_taken)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            step_q      <= '0;
            lz_q        <= '0;
            out_fp_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            step_q      <= step_d;
            lz_q        <= lz_d;
            out_fp_q    <= out_fp_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                  state_d = NORM;
            NORM:    if (step_q == '0)              state_d = PACK;
            PACK:                                   state_d = DONE;
            DONE:    if (out_valid_q && out_ready)  state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_comb begin
        sign_d   = sign_q;
        mag_d    = mag_q;
        step_d   = step_q;
        lz_d     = lz_q;
        out_fp_d = out_fp_q;
        w_exp    = EXP_BIT'(c_BIAS + (N_BIT - 1) - int'(lz_q));
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_signed & in_int[N_BIT-1];
                    mag_d  = (in_signed & in_int[N_BIT-1]) ? -in_int : in_int;
                    step_d = LOG_BIT'(LOG_BIT - 1);
                    lz_d   = '0;
                end
            end
            NORM: begin
                mag_d = w_shifted;
                lz_d  = lz_q + (w_taken ? (LOG_BIT'(1) << step_q) : '0);
                if (step_q != '0) step_d = step_q - 1'b1;
            end
            PACK: begin
                // A zero magnitude always packs to +0, regardless of the latched sign.
                if (mag_q == '0) begin
                    out_fp_d = '0;
                end else begin
                    out_fp_d.sign = sign_q;
                    out_fp_d.exp  = w_exp;
                    out_fp_d.man  = mag_q[N_BIT-2 -: MAN_BIT];
                end
            end
            default: ;
        endcase
        // out_valid is a register so the consumer sees a glitch-free flag; it drops on the taking edge.
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_fp    = out_fp_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_from_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_from_int
//  Description : Self-checking bench for fp_from_int (directed and random).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_from_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    fp_from_int #(
        .LOG_BIT (5),
        .EXP_BIT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: locate the leading one arithmetically and truncate to 23 fraction bits.
    function automatic logic [31:0] ref_fp(input logic [31:0] v, input logic s);
        longint unsigned m;
        logic            neg;
        int              p;
        logic [31:0]     man;
        neg = s && v[31];
        m   = neg ? (64'd4294967296 - 64'(v)) : 64'(v);
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 33; i++)
            if (m >= (64'd1 << i)) p = i;
        if (p >= 23) man = 32'(m >> (p - 23));
        else         man = 32'(m << (23 - p));
        return {neg, 8'(127 + p), man[22:0]};
    endfunction

    task automatic convert(input logic [31:0] v, input logic s, input logic [31:0] exp_fp,
                           input int hold, input bit keep_valid);
        int          n;
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        in_int    = v;
        in_signed = s;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_int    = $urandom;
        in_signed = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd7);
        chk("result", out_fp, exp_fp);
        held = out_fp;
        for (int i = 0; i < hold; i++) begin
            if (keep_valid) begin
                in_valid  = 1'b1;
                in_int    = 32'h1;
                in_signed = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_stable", out_fp, held);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic        s;
        int          seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_int    = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_fp", out_fp, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        convert(32'h00000001, 1'b0, 32'h3F800000, 0, 1'b0);
        convert(32'hFFFFFFFF, 1'b1, 32'hBF800000, 0, 1'b0);
        convert(32'h80000000, 1'b1, 32'hCF000000, 0, 1'b0);
        convert(32'h80000000, 1'b0, 32'h4F000000, 0, 1'b0);
        convert(32'h00000000, 1'b1, 32'h00000000, 0, 1'b0);
        convert(32'h00000000, 1'b0, 32'h00000000, 0, 1'b0);
        convert(32'h01000001, 1'b0, 32'h4B800000, 0, 1'b0);
        convert(32'hFFFFFFFF, 1'b0, 32'h4F7FFFFF, 0, 1'b0);
        convert(32'h7FFFFFFF, 1'b1, 32'h4EFFFFFF, 0, 1'b0);

        // Backpressure with a pending request held on the input side.
        convert(32'hFFFFFF00, 1'b1, 32'hC3800000, 10, 1'b1);
        convert(32'h00000001, 1'b0, 32'h3F800000, 0, 1'b0);

        // Reset in the third NORM cycle discards the conversion.
        @(negedge clk);
        in_int    = 32'h00012345;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        chk("mid_rst_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready_edge", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid_edge", 32'(out_valid), 32'd0);
        chk("mid_rst_out_fp", out_fp, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_release_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_stale_result", 32'(seen), 32'd0);
        convert(32'h00000003, 1'b0, 32'h40400000, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if (i % 3 == 0) v = ~v;
            s = 1'($urandom);
            convert(v, s, ref_fp(v, s), (i % 5 == 0) ? 2 : 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
